// File: rtl/arm_mc_ctrl_pkg.sv
// Shared encodings for the ARM-subset multi-cycle controller and the datapath mux decoders.
package arm_ctrl_pkg;

   typedef enum logic [3:0] {
      RST_S   = 4'd0,
      FETCH   = 4'd1,
      DECODE  = 4'd2,
      EX_DP   = 4'd3,
      EX_BR   = 4'd4,
      EX_BX   = 4'd5,
      MEM_RD  = 4'd6,
      MEM_WR  = 4'd7,
      BASE_WB = 4'd8,
      SWP_RD  = 4'd9,
      SWP_WR  = 4'd10,
      UND     = 4'd11
   } state_e;

   localparam logic [1:0] PC_SRC_INC  = 2'd0;
   localparam logic [1:0] PC_SRC_BR   = 2'd1;
   localparam logic [1:0] PC_SRC_RM   = 2'd2;

   localparam logic [1:0] REG_DST_RD  = 2'd0;
   localparam logic [1:0] REG_DST_LR  = 2'd1;
   localparam logic [1:0] REG_DST_RN  = 2'd2;

   localparam logic [1:0] WB_SRC_ALU  = 2'd0;
   localparam logic [1:0] WB_SRC_MEM  = 2'd1;
   localparam logic [1:0] WB_SRC_PC4  = 2'd2;

endpackage

// File: rtl/arm_mc_ctrl_if.sv
// Decoder/memory-side signal bundle between the control FSM (master) and the datapath (slave).
interface arm_mc_ctrl_if;

   logic       cmd_b, cmd_bl, cmd_bx, cmd_ldr, cmd_str, cmd_swp;
   logic       und_ins, cond_ok, ttcc, s_bit, p_bit, w_bit;
   logic       mem_ready;

   logic       ir_write, pc_write, reg_write, flag_write;
   logic [1:0] pc_src, reg_dst, wb_src;
   logic       mem_req, mem_we, mem_addr_src;
   logic       und_trap, bus_err, busy;

   modport master (
      input  cmd_b, cmd_bl, cmd_bx, cmd_ldr, cmd_str, cmd_swp,
      input  und_ins, cond_ok, ttcc, s_bit, p_bit, w_bit, mem_ready,
      output ir_write, pc_write, pc_src, reg_write, reg_dst, wb_src, flag_write,
      output mem_req, mem_we, mem_addr_src, und_trap, bus_err, busy
   );

   modport slave (
      output cmd_b, cmd_bl, cmd_bx, cmd_ldr, cmd_str, cmd_swp,
      output und_ins, cond_ok, ttcc, s_bit, p_bit, w_bit, mem_ready,
      input  ir_write, pc_write, pc_src, reg_write, reg_dst, wb_src, flag_write,
      input  mem_req, mem_we, mem_addr_src, und_trap, bus_err, busy
   );

endinterface

// File: rtl/arm_mc_ctrl_watchdog.sv
// Per-access wait-state counter; flags the wait cycle in which the count reaches MAX_WAIT.
module arm_mem_watchdog #(
   parameter int unsigned MAX_WAIT = 255,
   parameter int unsigned WCNT_W   = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic req_i,
   input  logic ready_i,
   output logic timeout_o
);

   logic [WCNT_W-1:0] cnt_q, cnt_d;

   // A ready in the final wait cycle masks the timeout.
   assign timeout_o = req_i & ~ready_i & (cnt_q == WCNT_W'(MAX_WAIT - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (req_i && !ready_i)
         cnt_d = cnt_q + WCNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/arm_mc_ctrl.sv
// Multi-cycle control FSM: fetch, decode, execute, memory and write-back sequencing.
module arm_mc_ctrl
   import arm_ctrl_pkg::*;
#(
   parameter int unsigned MAX_WAIT = 255,
   parameter int unsigned WCNT_W   = 8
) (
   input  logic          clk,
   input  logic          rst,
   arm_mc_ctrl_if.master bus_io
);

   state_e state_q, state_d;
   logic   req, timeout, wd_clr;
   logic   rdy, base_wb;

   assign rdy     = bus_io.mem_ready;
   assign base_wb = bus_io.w_bit | ~bus_io.p_bit;
   assign req     = (state_q == FETCH)  || (state_q == MEM_RD) || (state_q == MEM_WR) ||
                    (state_q == SWP_RD) || (state_q == SWP_WR);
   // Any state change enters a fresh access; a FETCH timeout re-enters FETCH itself.
   assign wd_clr  = (state_d != state_q) | timeout;

   arm_mem_watchdog #(.MAX_WAIT(MAX_WAIT), .WCNT_W(WCNT_W)) u_wdog (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (wd_clr),
      .req_i     (req),
      .ready_i   (rdy),
      .timeout_o (timeout)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state_q <= RST_S;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         RST_S:  state_d = FETCH;
         FETCH:  if (rdy) state_d = DECODE;
         DECODE: begin
            if (!bus_io.cond_ok)                    state_d = FETCH;
            else if (bus_io.und_ins)                state_d = UND;
            else if (bus_io.cmd_bx)                 state_d = EX_BX;
            else if (bus_io.cmd_b || bus_io.cmd_bl) state_d = EX_BR;
            else if (bus_io.cmd_ldr)                state_d = MEM_RD;
            else if (bus_io.cmd_str)                state_d = MEM_WR;
            else if (bus_io.cmd_swp)                state_d = SWP_RD;
            else                                    state_d = EX_DP;
         end
         MEM_RD, MEM_WR: begin
            if (rdy)          state_d = base_wb ? BASE_WB : FETCH;
            else if (timeout) state_d = FETCH;
         end
         SWP_RD: begin
            if (rdy)          state_d = SWP_WR;
            else if (timeout) state_d = FETCH;
         end
         SWP_WR: if (rdy || timeout) state_d = FETCH;
         default: state_d = FETCH;
      endcase
   end

   always_comb begin
      bus_io.ir_write     = 1'b0;
      bus_io.pc_write     = 1'b0;
      bus_io.pc_src       = PC_SRC_INC;
      bus_io.reg_write    = 1'b0;
      bus_io.reg_dst      = REG_DST_RD;
      bus_io.wb_src       = WB_SRC_ALU;
      bus_io.flag_write   = 1'b0;
      bus_io.mem_req      = req;
      bus_io.mem_we       = 1'b0;
      bus_io.mem_addr_src = 1'b0;
      bus_io.und_trap     = 1'b0;
      bus_io.bus_err      = timeout;
      bus_io.busy         = (state_q != RST_S) && (state_q != FETCH);
      case (state_q)
         FETCH: begin
            bus_io.ir_write = rdy;
            bus_io.pc_write = rdy;
         end
         EX_DP: begin
            bus_io.reg_write  = ~bus_io.ttcc;
            bus_io.flag_write = bus_io.s_bit;
         end
         EX_BR: begin
            bus_io.pc_write  = 1'b1;
            bus_io.pc_src    = PC_SRC_BR;
            bus_io.reg_write = bus_io.cmd_bl;
            bus_io.reg_dst   = REG_DST_LR;
            bus_io.wb_src    = WB_SRC_PC4;
         end
         EX_BX: begin
            bus_io.pc_write = 1'b1;
            bus_io.pc_src   = PC_SRC_RM;
         end
         MEM_RD, SWP_WR: begin
            bus_io.mem_we       = (state_q == SWP_WR);
            bus_io.mem_addr_src = 1'b1;
            bus_io.reg_write    = rdy;
            bus_io.wb_src       = WB_SRC_MEM;
         end
         MEM_WR: begin
            bus_io.mem_we       = 1'b1;
            bus_io.mem_addr_src = 1'b1;
         end
         SWP_RD: bus_io.mem_addr_src = 1'b1;
         BASE_WB: begin
            bus_io.reg_write = 1'b1;
            bus_io.reg_dst   = REG_DST_RN;
         end
         UND: bus_io.und_trap = 1'b1;
         default: ;
      endcase
   end

endmodule
